// File: rtl/field_engine.sv
// field_engine: byte-serial MIX partial-field unit (LD / LDN / ST) on sign-magnitude words.
// Optional macro FIELD_ENGINE_FAST_EN: legal full-magnitude fields complete one cycle after accept.
module field_engine #(
  parameter  int BYTE_W = 6,
  parameter  int NBYTES = 5,
  localparam int W      = 1 + NBYTES*BYTE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [5:0]   field,
  input  logic [W-1:0] reg_in,
  input  logic [W-1:0] mem_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy
);

  localparam int MW = NBYTES*BYTE_W;

  localparam logic [1:0] OP_LDN = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state;
  logic [1:0]      op_q;
  logic [2:0]      lp_q;
  logic [2:0]      r_q;
  logic [2:0]      n_q;
  logic [2:0]      j_q;
  logic [MW-1:0]   reg_q;
  logic [W-1:0]    acc;

  // Byte k (1 = most significant) of a magnitude.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [MW-1:0] mag, input logic [2:0] k);
    return BYTE_W'(mag >> ((NBYTES - int'(k)) * BYTE_W));
  endfunction

  function automatic logic [W-1:0] with_byte(input logic [W-1:0] word, input logic [2:0] k,
                                             input logic [BYTE_W-1:0] b);
    logic [W-1:0] w;
    w = word;
    for (int i = 1; i <= NBYTES; i++)
      if (int'(k) == i) w[(NBYTES-i+1)*BYTE_W-1 -: BYTE_W] = b;
    return w;
  endfunction

  function automatic logic [W-1:0] finish(input logic [1:0] o, input logic [W-1:0] w);
    return {w[W-1] ^ (o == OP_LDN), w[MW-1:0]};
  endfunction

  logic [2:0]   l_in, r_in, lp_in, n_in;
  logic         legal_in;
  logic [W-1:0] init_acc, illegal_word, acc_next;

  // NOTE: every combinational output gets a default at the top so no path can infer a latch.
  always_comb begin
    l_in         = field[5:3];
    r_in         = field[2:0];
    lp_in        = (l_in == 3'd0) ? 3'd1 : l_in;
    legal_in     = (l_in <= r_in) && (int'(r_in) <= NBYTES) && (op != OP_RSV);
    n_in         = (r_in == 3'd0) ? 3'd0 : (r_in - lp_in + 3'd1);
    illegal_word = (op == OP_ST) ? mem_in : '0;
    if (op == OP_ST)
      init_acc = {(l_in == 3'd0) ? reg_in[W-1] : mem_in[W-1], mem_in[MW-1:0]};
    else
      init_acc = {(l_in == 3'd0) & reg_in[W-1], {MW{1'b0}}};

    if (op_q == OP_ST)
      acc_next = with_byte(acc, r_q - j_q, byte_of(reg_q, 3'(NBYTES) - j_q));
    else
      acc_next = {acc[W-1], (acc[MW-1:0] << BYTE_W) | MW'(byte_of(reg_q, lp_q + j_q))};
  end

`ifdef FIELD_ENGINE_FAST_EN
  logic fast_in;
  assign fast_in = legal_in && (l_in <= 3'd1) && (int'(r_in) == NBYTES);
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      lp_q      <= '0;
      r_q       <= '0;
      n_q       <= '0;
      j_q       <= '0;
      reg_q     <= '0;
      acc       <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q     <= op;
          lp_q     <= lp_in;
          r_q      <= r_in;
          n_q      <= n_in;
          j_q      <= '0;
          reg_q    <= reg_in[MW-1:0];
          in_ready <= 1'b0;
          if (!legal_in) begin
            state     <= DONE;
            out_valid <= 1'b1;
            err       <= 1'b1;
            result    <= illegal_word;
`ifdef FIELD_ENGINE_FAST_EN
          end else if (fast_in) begin
            // Full-magnitude field: every byte comes from the register, only the sign differs.
            state     <= DONE;
            out_valid <= 1'b1;
            err       <= 1'b0;
            result    <= finish(op, {init_acc[W-1], reg_in[MW-1:0]});
`endif
          end else if (n_in == 3'd0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            err       <= 1'b0;
            result    <= finish(op, init_acc);
          end else begin
            state <= BUSY;
            busy  <= 1'b1;
            err   <= 1'b0;
            acc   <= init_acc;
          end
        end
        BUSY: begin
          acc <= acc_next;
          j_q <= j_q + 3'd1;
          if (j_q == n_q - 3'd1) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= finish(op_q, acc_next);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          err       <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
